// File: rtl/bpm_pkg.sv
// Shared constants and FSM state encoding for the BPM window averager.
package bpm_pkg;

   localparam int unsigned BPM_W         = 8;
   localparam int unsigned BPM_MIN_DFLT  = 30;
   localparam int unsigned BPM_MAX_DFLT  = 220;
   localparam int unsigned ALARM_HI_DFLT = 120;
   localparam int unsigned ALARM_LO_DFLT = 50;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACK,
      ST_CHECK,
      ST_UPDATE,
      ST_WAIT_LOW
   } state_e;

endpackage

// File: rtl/bpm_ring_buf.sv
// Ring of the last 2**WIN_LOG2 accepted readings; exposes the slot about to be
// overwritten and whether the window is full once the pending write lands.
module bpm_ring_buf
   import bpm_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [BPM_W-1:0] wr_data,
   output logic [BPM_W-1:0] old_data,
   output logic             full_next
);

   localparam int unsigned DEPTH  = 1 << WIN_LOG2;
   localparam int unsigned FILL_W = WIN_LOG2 + 1;
   localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

   logic [BPM_W-1:0]    slot_q [DEPTH];
   logic [BPM_W-1:0]    slot_d [DEPTH];
   logic [WIN_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FILL_W-1:0]   fill_q, fill_d;

   always_comb begin
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (wr_en) begin
         slot_d[wr_ptr_q] = wr_data;
         wr_ptr_d         = wr_ptr_q + 1'b1;
         if (fill_q != DEPTH_F) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   // Read of the outgoing slot happens before the write, so the caller can
   // subtract it from the running sum in the same cycle.
   assign old_data  = slot_q[wr_ptr_q];
   assign full_next = wr_en && (fill_d == DEPTH_F);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         slot_q   <= slot_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

endmodule

// File: rtl/bpm_averager.sv
// Windowed mean of plausible BPM readings with handshake, reject counter and
// overrun flag. Define BPM_ALARM_EN to build the high/low rate alarms.
module bpm_averager
   import bpm_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 2,
   parameter int unsigned BPM_MIN  = BPM_MIN_DFLT,
   parameter int unsigned BPM_MAX  = BPM_MAX_DFLT,
   parameter int unsigned ALARM_HI = ALARM_HI_DFLT,
   parameter int unsigned ALARM_LO = ALARM_LO_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [BPM_W-1:0] bpm_value,
   input  logic             bpm_valid,
   output logic             bpm_copied,
   output logic [BPM_W-1:0] avg_bpm,
   output logic             avg_valid,
   input  logic             avg_ack,
   output logic             overrun,
   output logic [BPM_W-1:0] rej_cnt,
   output logic             alarm_hi,
   output logic             alarm_lo
);

   localparam int unsigned SUM_W = BPM_W + WIN_LOG2;
   localparam logic [BPM_W-1:0] MIN_V = BPM_W'(BPM_MIN);
   localparam logic [BPM_W-1:0] MAX_V = BPM_W'(BPM_MAX);

   state_e           state_q, state_d;
   logic [BPM_W-1:0] reading_q, reading_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [BPM_W-1:0] avg_q, avg_d;
   logic             avg_valid_q, avg_valid_d;
   logic             overrun_q, overrun_d;
   logic [BPM_W-1:0] rej_cnt_q, rej_cnt_d;
   logic             publish;
   logic             ring_wr;
   logic [BPM_W-1:0] old_slot;
   logic             ring_full_next;

   assign ring_wr = (state_q == ST_UPDATE);

   bpm_ring_buf #(
      .WIN_LOG2 (WIN_LOG2)
   ) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (ring_wr),
      .wr_data   (reading_q),
      .old_data  (old_slot),
      .full_next (ring_full_next)
   );

   always_comb begin
      state_d     = state_q;
      reading_d   = reading_q;
      sum_d       = sum_q;
      avg_d       = avg_q;
      avg_valid_d = avg_valid_q;
      overrun_d   = overrun_q;
      rej_cnt_d   = rej_cnt_q;
      publish     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en && bpm_valid) begin
               reading_d = bpm_value;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if ((reading_q < MIN_V) || (reading_q > MAX_V)) begin
               if (rej_cnt_q != 8'hFF) begin
                  rej_cnt_d = rej_cnt_q + 1'b1;
               end
               state_d = ST_WAIT_LOW;
            end else begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            sum_d   = sum_q - SUM_W'(old_slot) + SUM_W'(reading_q);
            publish = ring_full_next;
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // Upstream holds valid until it sees the copy pulse; wait for it to drop.
            if (!bpm_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (publish) begin
         avg_d       = BPM_W'(sum_d >> WIN_LOG2);
         avg_valid_d = 1'b1;
         if (avg_valid_q && !avg_ack) begin
            overrun_d = 1'b1;
         end
      end else if (avg_ack) begin
         avg_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         reading_q   <= '0;
         sum_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         rej_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         reading_q   <= reading_d;
         sum_q       <= sum_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         overrun_q   <= overrun_d;
         rej_cnt_q   <= rej_cnt_d;
      end
   end

   assign bpm_copied = (state_q == ST_ACK);
   assign avg_bpm    = avg_q;
   assign avg_valid  = avg_valid_q;
   assign overrun    = overrun_q;
   assign rej_cnt    = rej_cnt_q;

`ifdef BPM_ALARM_EN
   localparam logic [BPM_W-1:0] HI_V = BPM_W'(ALARM_HI);
   localparam logic [BPM_W-1:0] LO_V = BPM_W'(ALARM_LO);

   logic alarm_hi_q, alarm_hi_d;
   logic alarm_lo_q, alarm_lo_d;

   always_comb begin
      alarm_hi_d = alarm_hi_q;
      alarm_lo_d = alarm_lo_q;
      if (publish) begin
         alarm_hi_d = (avg_d > HI_V);
         alarm_lo_d = (avg_d < LO_V);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alarm_hi_q <= 1'b0;
         alarm_lo_q <= 1'b0;
      end else begin
         alarm_hi_q <= alarm_hi_d;
         alarm_lo_q <= alarm_lo_d;
      end
   end

   assign alarm_hi = alarm_hi_q;
   assign alarm_lo = alarm_lo_q;
`else
   assign alarm_hi = 1'b0;
   assign alarm_lo = 1'b0;
`endif

endmodule

// File: tb/tb_bpm_averager.sv
// Directed bench for bpm_averager: reset, averaging, wrap, rejects, overrun, alarms.
module tb_bpm_averager;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] bpm_value;
   logic       bpm_valid;
   logic       bpm_copied;
   logic [7:0] avg_bpm;
   logic       avg_valid;
   logic       avg_ack;
   logic       overrun;
   logic [7:0] rej_cnt;
   logic       alarm_hi;
   logic       alarm_lo;

   int n_cmp;
   int n_bad;
   int cp_cnt;
   int cp_base;
   logic v2;
   logic v3;

   bpm_averager dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .bpm_value  (bpm_value),
      .bpm_valid  (bpm_valid),
      .bpm_copied (bpm_copied),
      .avg_bpm    (avg_bpm),
      .avg_valid  (avg_valid),
      .avg_ack    (avg_ack),
      .overrun    (overrun),
      .rej_cnt    (rej_cnt),
      .alarm_hi   (alarm_hi),
      .alarm_lo   (alarm_lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cp_cnt = 0;
   always @(negedge clk) begin
      if (bpm_copied === 1'b1) cp_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = 1'b1;
      bpm_valid = 1'b0;
      bpm_value = '0;
      avg_ack   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called on a falling edge; returns with the FSM back in IDLE.
   task automatic send(input logic [7:0] v, input bit ack_pub);
      bit seen;
      seen      = 1'b0;
      bpm_valid = 1'b1;
      bpm_value = v;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bpm_copied === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("copied_timeout", 32'd0, 32'd1);
      bpm_valid = 1'b0;
      @(negedge clk);
      chk("copied_one_cycle", 32'(bpm_copied), 32'd0);
      @(negedge clk);
      v2 = avg_valid;
      if (ack_pub) avg_ack = 1'b1;
      @(negedge clk);
      v3 = avg_valid;
      avg_ack = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_ack();
      avg_ack = 1'b1;
      @(negedge clk);
      avg_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      v2    = 1'b0;
      v3    = 1'b0;

      // Reset held with random inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en        = 1'($urandom);
         bpm_valid = 1'($urandom);
         bpm_value = 8'($urandom);
         avg_ack   = 1'($urandom);
         @(negedge clk);
         chk("reset_outputs",
             32'({bpm_copied, avg_bpm, avg_valid, overrun, rej_cnt, alarm_hi, alarm_lo}),
             32'd0);
      end
      do_reset();

      // Four identical readings.
      cp_base = cp_cnt;
      send(8'd72, 1'b0);
      send(8'd72, 1'b0);
      send(8'd72, 1'b0);
      chk("no_pub_after_3", 32'(avg_valid), 32'd0);
      send(8'd72, 1'b0);
      chk("lat_before", 32'(v2), 32'd0);
      chk("lat_at_3", 32'(v3), 32'd1);
      chk("avg_72", 32'(avg_bpm), 32'd72);
      chk("valid_72", 32'(avg_valid), 32'd1);
      chk("copied_x4", 32'(cp_cnt - cp_base), 32'd4);
      do_ack();
      chk("ack_clears", 32'(avg_valid), 32'd0);

      // Ramp, then wrap replacing the oldest.
      do_reset();
      send(8'd60, 1'b0);
      send(8'd64, 1'b0);
      send(8'd68, 1'b0);
      send(8'd72, 1'b0);
      chk("avg_66", 32'(avg_bpm), 32'd66);
      do_ack();
      send(8'd100, 1'b0);
      chk("avg_76", 32'(avg_bpm), 32'd76);
      chk("valid_76", 32'(avg_valid), 32'd1);
      chk("no_ovr_acked", 32'(overrun), 32'd0);

      // Out-of-range readings are acknowledged but kept out of the window.
      do_reset();
      cp_base = cp_cnt;
      send(8'd250, 1'b0);
      send(8'd20, 1'b0);
      chk("rej_copied", 32'(cp_cnt - cp_base), 32'd2);
      chk("rej_cnt_2", 32'(rej_cnt), 32'd2);
      send(8'd80, 1'b0);
      send(8'd80, 1'b0);
      send(8'd80, 1'b0);
      chk("rej_no_fill", 32'(avg_valid), 32'd0);
      send(8'd80, 1'b0);
      chk("avg_80", 32'(avg_bpm), 32'd80);
      chk("valid_80", 32'(avg_valid), 32'd1);
      chk("rej_cnt_hold", 32'(rej_cnt), 32'd2);

      // Overrun on unacknowledged republish.
      do_reset();
      for (int i = 0; i < 4; i++) send(8'd72, 1'b0);
      chk("ovr_pre", 32'(overrun), 32'd0);
      send(8'd72, 1'b0);
      chk("ovr_set", 32'(overrun), 32'd1);
      do_ack();
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Acknowledge in the publish cycle: no overrun, valid stays high.
      do_reset();
      for (int i = 0; i < 4; i++) send(8'd72, 1'b0);
      send(8'd72, 1'b1);
      chk("ack_pub_ovr", 32'(overrun), 32'd0);
      chk("ack_pub_valid", 32'(avg_valid), 32'd1);

      // Rate alarms.
      do_reset();
      for (int i = 0; i < 4; i++) send(8'd130, 1'b0);
      chk("avg_130", 32'(avg_bpm), 32'd130);
`ifdef BPM_ALARM_EN
      chk("alarm_hi_130", 32'(alarm_hi), 32'd1);
`else
      chk("alarm_hi_130", 32'(alarm_hi), 32'd0);
`endif
      chk("alarm_lo_130", 32'(alarm_lo), 32'd0);
      for (int i = 0; i < 4; i++) send(8'd40, 1'b0);
      chk("avg_40", 32'(avg_bpm), 32'd40);
      chk("alarm_hi_40", 32'(alarm_hi), 32'd0);
`ifdef BPM_ALARM_EN
      chk("alarm_lo_40", 32'(alarm_lo), 32'd1);
`else
      chk("alarm_lo_40", 32'(alarm_lo), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bpm_averager.md
BPM_AVERAGER -- requirements
Module: bpm_averager

Interface
REQ-001 Parameter WIN_LOG2, default 2: log2 of the averaging window; the window is 4 readings.
REQ-002 Parameter BPM_MIN, default 30: lowest plausible reading.
REQ-003 Parameter BPM_MAX, default 220: highest plausible reading.
REQ-004 Parameter ALARM_HI, default 120: high-rate alarm threshold.
REQ-005 Parameter ALARM_LO, default 50: low-rate alarm threshold.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 en  in  1  accept new readings while high.
REQ-009 bpm_value  in  8  BPM reading from the upstream DigitalBlock.
REQ-010 bpm_valid  in  1  upstream reading available; held until copied.
REQ-011 bpm_copied  out  1  one-cycle acknowledge to upstream.
REQ-012 avg_bpm  out  8  windowed mean BPM.
REQ-013 avg_valid  out  1  avg_bpm is new; held until avg_ack.
REQ-014 avg_ack  in  1  consumer has taken avg_bpm.
REQ-015 overrun  out  1  sticky: an unacked average was overwritten.
REQ-016 rej_cnt  out  8  count of rejected readings, saturating.
REQ-017 alarm_hi / alarm_lo  out  1 each  rate alarms (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, ACK, CHECK, UPDATE and WAIT_LOW.
REQ-019 IDLE SHALL go to ACK when en=1 and bpm_valid=1, latching bpm_value.
REQ-020 bpm_copied SHALL be high exactly one cycle, during ACK; ACK always goes to CHECK.
REQ-021 CHECK: a reading below BPM_MIN or above BPM_MAX SHALL increment rej_cnt (saturating at 255), leave the window untouched and go to WAIT_LOW; otherwise go to UPDATE.
REQ-022 UPDATE SHALL write the reading into the ring slot at wr_ptr and set sum = sum - old_slot + reading.
- wr_ptr wraps modulo 4.
- sum width is 8+WIN_LOG2 bits and never overflows.
- fill count saturates at 4.
REQ-023 When fill count reaches 4, UPDATE SHALL load avg_bpm = sum >> WIN_LOG2 (truncating) and set avg_valid=1 on the next cycle. Before the window is full, nothing is published.
REQ-024 Latency: avg_valid SHALL rise 3 cycles after bpm_copied rises.
REQ-025 Overrun: publishing while avg_valid=1 and avg_ack=0 SHALL set overrun, which stays set until reset. Publish together with avg_ack SHALL keep avg_valid=1 and SHALL NOT set overrun.
REQ-026 avg_ack with no publish in the same cycle SHALL clear avg_valid next cycle. avg_ack while avg_valid=0 SHALL be ignored.
REQ-027 WAIT_LOW SHALL return to IDLE only after bpm_valid is sampled low, so a reading is never consumed twice.
REQ-028 en going low mid-transaction SHALL NOT abort it; only IDLE honours en.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state IDLE and clear all of the following to 0: bpm_copied, avg_bpm, avg_valid, overrun, rej_cnt, alarm_hi, alarm_lo, sum, wr_ptr, fill count and ring contents.
REQ-030 Reset SHALL win over any in-flight transaction in the same cycle.

Configuration
REQ-031 With macro BPM_ALARM_EN defined, each publish SHALL update the alarms:
- alarm_hi = (avg > ALARM_HI)
- alarm_lo = (avg < ALARM_LO)
- both hold until the next publish.
REQ-032 Without BPM_ALARM_EN, alarm_hi and alarm_lo SHALL be tied to 0 with no comparator logic; the port list is unchanged.

Structure
REQ-033 Package bpm_pkg SHALL hold BPM_W=8, the FSM state enum and the default BPM_MIN, BPM_MAX, ALARM_HI and ALARM_LO constants.
REQ-034 The ring buffer (storage, wr_ptr, fill count, old-slot read) SHALL be sub-module bpm_ring_buf.

Verification
REQ-035 Hold rst_n=0 for 5 cycles with random inputs -> every output is 0 and no bpm_copied pulse occurs.
REQ-036 Readings 72,72,72,72 with a testbench-style handshake:
- bpm_copied pulses exactly 4 times;
- after the 4th reading, avg_bpm=72 and avg_valid=1;
- avg_valid does not rise after the 3rd reading.
REQ-037 Readings 60,64,68,72 then 100 -> avg_bpm=66, then 76 (wrap-around replaces the 60).
REQ-038 Reading 250, then 20 -> each is acknowledged, rej_cnt=2 and the window is unchanged; a later 4x80 publishes 80.
REQ-039 Two publishes with no avg_ack -> overrun=1. Repeat after reset with avg_ack in the publish cycle -> overrun=0 and avg_valid=1.
REQ-040 4x130 then 4x40:
- with BPM_ALARM_EN: alarm_hi=1, then alarm_hi=0 and alarm_lo=1;
- without the macro: both alarms stay 0.
